// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 64-bit datapath: FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// with ready-handshaked memory, a wait-state timeout trap and a retired-instruction counter.
module multicycle_control #(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 alu_src,
    output logic [1:0]           alu_op,
    output logic                 branch,
    output logic                 reg_write,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] retired
);
    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_DEC   = 3'd1;
    localparam logic [2:0] S_EXE   = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_TRAP  = 3'd7;

    localparam logic [1:0] C_R   = 2'd0;
    localparam logic [1:0] C_LD  = 2'd1;
    localparam logic [1:0] C_SD  = 2'd2;
    localparam logic [1:0] C_BEQ = 2'd3;

    // Counter only ever reaches MEM_TIMEOUT-1 before a transition or trap.
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    logic [2:0]           state_q, state_d;
    logic [1:0]           cls_q, cls_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic                 ill_q, ill_d, to_q, to_d;
    logic [CNT_WIDTH-1:0] ret_q;
    logic                 ret_inc;

    logic       legal;
    logic [1:0] cls_dec;
    logic       pcw_s, pcs_s, irw_s, mrd_s, mwr_s, m2r_s, asrc_s, br_s, rw_s;
    logic [1:0] aop_s;

    always_comb begin
        legal   = 1'b1;
        cls_dec = C_R;
        case (opcode)
            7'b0110011: cls_dec = C_R;
            7'b0000011: cls_dec = C_LD;
            7'b0100011: cls_dec = C_SD;
            7'b1100011: cls_dec = C_BEQ;
            default:    legal   = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        ill_d   = ill_q;
        to_d    = to_q;
        ret_inc = 1'b0;
        pcw_s = 1'b0; pcs_s = 1'b0; irw_s = 1'b0; mrd_s = 1'b0; mwr_s = 1'b0;
        m2r_s = 1'b0; asrc_s = 1'b0; br_s = 1'b0; rw_s = 1'b0; aop_s = 2'b00;
        case (state_q)
            S_FETCH: begin
                mrd_s = 1'b1;
                if (mem_ready) begin
                    irw_s   = 1'b1;
                    pcw_s   = 1'b1;
                    state_d = S_DEC;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    to_d    = 1'b1;
                end
            end
            S_DEC: begin
                if (legal) begin
                    cls_d   = cls_dec;
                    state_d = S_EXE;
                end else begin
                    state_d = S_TRAP;
                    ill_d   = 1'b1;
                end
            end
            S_EXE: begin
                case (cls_q)
                    C_R: begin
                        aop_s   = 2'b10;
                        state_d = S_WB;
                    end
                    C_LD, C_SD: begin
                        asrc_s  = 1'b1;
                        state_d = S_MEM;
                    end
                    default: begin
                        aop_s   = 2'b01;
                        br_s    = 1'b1;
                        pcw_s   = zero;
                        pcs_s   = zero;
                        state_d = S_FETCH;
                        ret_inc = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                asrc_s = 1'b1;
                mwr_s  = (cls_q == C_SD);
                mrd_s  = (cls_q != C_SD);
                if (mem_ready) begin
                    if (cls_q == C_SD) begin
                        state_d = S_FETCH;
                        ret_inc = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    to_d    = 1'b1;
                end
            end
            S_WB: begin
                rw_s    = 1'b1;
                m2r_s   = (cls_q == C_LD);
                state_d = S_FETCH;
                ret_inc = 1'b1;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        // Any state change restarts the wait count for the next handshake.
        if (state_d != state_q)
            wait_d = '0;
        else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
            wait_d = wait_q + 1'b1;
        else
            wait_d = wait_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= C_R;
            wait_q  <= '0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            ill_q   <= ill_d;
            to_q    <= to_d;
            if (ret_inc) ret_q <= ret_q + 1'b1;
        end
    end

    // Strobes are squashed while reset is high so no write escapes mid-reset.
    assign pc_write   = pcw_s  & ~reset;
    assign pc_src     = pcs_s  & ~reset;
    assign ir_write   = irw_s  & ~reset;
    assign mem_read   = mrd_s  & ~reset;
    assign mem_write  = mwr_s  & ~reset;
    assign mem_to_reg = m2r_s  & ~reset;
    assign alu_src    = asrc_s & ~reset;
    assign alu_op     = aop_s  & {2{~reset}};
    assign branch     = br_s   & ~reset;
    assign reg_write  = rw_s   & ~reset;
    assign state      = state_q;
    assign illegal    = ill_q;
    assign timeout    = to_q;
    assign retired    = ret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed checks of multicycle_control with CNT_WIDTH=4, MEM_TIMEOUT=4.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [6:0] opcode;
    logic       pc_write, pc_src, ir_write, mem_read, mem_write, mem_to_reg;
    logic       alu_src, branch, reg_write, illegal, timeout;
    logic [1:0] alu_op;
    logic [2:0] state;
    logic [3:0] retired;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    multicycle_control #(.CNT_WIDTH(4), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
        .branch(branch), .reg_write(reg_write), .state(state), .illegal(illegal),
        .timeout(timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    wire [10:0] strobes = {pc_write, pc_src, ir_write, mem_read, mem_write, mem_to_reg,
                           alu_src, alu_op, branch, reg_write};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = OP_R;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_retired", retired, 0);
        chk("rst_flags", {illegal, timeout}, 0);
        chk("rst_strobes", strobes, 0);
        reset = 1'b0; #1;
        chk("first_mem_read", mem_read, 1);

        // R-type, zero wait
        mem_ready = 1'b1; #1;
        chk("r_fetch", {state, ir_write, pc_write, pc_src}, {3'd0, 3'b110});
        tick(); chk("r_dec", {state, strobes}, {3'd1, 11'd0});
        tick(); chk("r_exe", {state, alu_op, alu_src}, {3'd2, 2'b10, 1'b0});
        chk("r_exe_rw", reg_write, 0);
        tick(); chk("r_wb", {state, reg_write, mem_to_reg}, {3'd4, 2'b10});
        tick(); chk("r_done", {state, reg_write}, {3'd0, 1'b0});
        chk("r_retired", retired, 1);

        // ld with 2 data wait cycles; IR change in EXECUTE must be ignored
        opcode = OP_LD; #1;
        tick(); chk("ld_dec", state, 1);
        tick(); opcode = OP_R; #1;
        chk("ld_exe", {state, alu_op, alu_src}, {3'd2, 2'b00, 1'b1});
        tick(); mem_ready = 1'b0; #1;
        chk("ld_mem0", {state, mem_read, alu_src, mem_write}, {3'd3, 3'b110});
        tick(); chk("ld_mem1", {state, mem_read}, {3'd3, 1'b1});
        tick(); mem_ready = 1'b1; #1;
        chk("ld_mem2", {state, mem_read}, {3'd3, 1'b1});
        tick(); chk("ld_wb", {state, reg_write, mem_to_reg}, {3'd4, 2'b11});
        tick(); chk("ld_done", {state, retired}, {3'd0, 4'd2});

        // beq taken, then not taken
        opcode = OP_BEQ; zero = 1'b1;
        tick(); tick();
        chk("beq_t_exe", {state, branch, pc_write, pc_src, alu_op}, {3'd2, 3'b111, 2'b01});
        tick(); chk("beq_t_done", {state, retired}, {3'd0, 4'd3});
        zero = 1'b0;
        tick(); tick();
        chk("beq_n_exe", {state, branch, pc_write, pc_src}, {3'd2, 3'b100});
        tick(); chk("beq_n_done", {state, retired}, {3'd0, 4'd4});

        // sd, zero wait
        opcode = OP_SD;
        tick(); tick(); tick();
        chk("sd_mem", {state, mem_write, mem_read, alu_src}, {3'd3, 3'b101});
        tick(); chk("sd_done", {state, retired}, {3'd0, 4'd5});

        // illegal opcode traps
        opcode = 7'b1111111;
        tick(); chk("ill_dec", {state, strobes}, {3'd1, 11'd0});
        tick(); chk("ill_trap", {state, illegal, timeout}, {3'd7, 2'b10});
        for (int i = 0; i < 10; i++) begin
            tick(); chk("ill_hold", {state, strobes, illegal}, {3'd7, 11'd0, 1'b1});
        end
        reset = 1'b1;
        tick(); reset = 1'b0; #1;
        chk("ill_reset", {state, illegal, retired}, {3'd0, 1'b0, 4'd0});

        // fetch timeout after exactly 4 waiting cycles
        mem_ready = 1'b0; opcode = OP_R;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("to_wait", {state, timeout}, {3'd0, 1'b0});
        end
        tick(); chk("to_trap", {state, timeout, strobes}, {3'd7, 1'b1, 11'd0});
        reset = 1'b1;
        tick(); reset = 1'b0; #1;
        chk("to_reset", {state, timeout}, {3'd0, 1'b0});

        // ready on the last allowed cycle wins
        tick(); tick(); tick();
        mem_ready = 1'b1; #1;
        chk("to_edge_ir", {state, ir_write}, {3'd0, 1'b1});
        tick(); chk("to_edge_dec", {state, timeout}, {3'd1, 1'b0});
        tick(); tick(); tick();
        chk("to_edge_done", {state, retired}, {3'd0, 4'd1});

        // retired counter wrap
        reset = 1'b1;
        tick(); reset = 1'b0; #1;
        for (int i = 1; i <= 17; i++) begin
            tick(); tick(); tick(); tick();
            chk("wrap_retired", {state, retired}, {3'd0, 4'(i)});
        end

        // reset during sd in MEM
        opcode = OP_SD;
        tick(); tick(); tick();
        mem_ready = 1'b0; #1;
        chk("sdr_mem", {state, mem_write}, {3'd3, 1'b1});
        reset = 1'b1; #1;
        chk("sdr_squash", strobes, 0);
        tick(); chk("sdr_state", state, 0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
